// File: rtl/mem_access_unit.sv
// MEM pipeline stage with MEM/WB latch: runs loads/stores through the memory-controller handshake.
// Optional define MEM_FWD_EN compiles in the combinational forward path to decode.
module mem_access_unit #(
    parameter int unsigned CMD_W = 6,
    parameter logic [CMD_W-1:0] CmdLB  = CMD_W'(11),
    parameter logic [CMD_W-1:0] CmdLH  = CMD_W'(12),
    parameter logic [CMD_W-1:0] CmdLW  = CMD_W'(13),
    parameter logic [CMD_W-1:0] CmdLBU = CMD_W'(14),
    parameter logic [CMD_W-1:0] CmdLHU = CMD_W'(15),
    parameter logic [CMD_W-1:0] CmdSB  = CMD_W'(16),
    parameter logic [CMD_W-1:0] CmdSH  = CMD_W'(17),
    parameter logic [CMD_W-1:0] CmdSW  = CMD_W'(18)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [4:0]       rsd_addr_in,
    input  logic [31:0]      rsd_data_in,
    input  logic             write_rsd_in,
    input  logic [CMD_W-1:0] cmdtype_in,
    input  logic [31:0]      mem_addr_in,
    input  logic [31:0]      store_val_in,
    output logic             mctl_req_o,
    output logic             mctl_we_o,
    output logic [31:0]      mctl_addr_o,
    output logic [2:0]       mctl_len_o,
    output logic [31:0]      mctl_wdata_o,
    input  logic             mctl_done_i,
    input  logic [31:0]      mctl_rdata_i,
    output logic [4:0]       rsd_addr_o,
    output logic [31:0]      rsd_data_o,
    output logic             write_rsd_o,
    output logic             stall_mem_o,
    output logic             mem_forward_id_o,
    output logic [4:0]       mem_forward_addr_o,
    output logic [31:0]      mem_forward_data_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [2:0]       r_len;
    logic [31:0]      r_wdata;
    logic [CMD_W-1:0] r_cmd;
    logic [4:0]       r_rd;
    logic [4:0]       r_rsd_addr;
    logic [31:0]      r_rsd_data;
    logic             r_write_rsd;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_is_mem;
    logic [2:0]       w_len;
    logic [31:0]      w_load_ext;
    logic             w_stall;

    // Decode of the incoming command; unknown codes fall through as non-memory.
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_len      = 3'd4;
        case (cmdtype_in)
            CmdLB, CmdLBU: begin w_is_load  = 1'b1; w_len = 3'd1; end
            CmdLH, CmdLHU: begin w_is_load  = 1'b1; w_len = 3'd2; end
            CmdLW:         begin w_is_load  = 1'b1; w_len = 3'd4; end
            CmdSB:         begin w_is_store = 1'b1; w_len = 3'd1; end
            CmdSH:         begin w_is_store = 1'b1; w_len = 3'd2; end
            CmdSW:         begin w_is_store = 1'b1; w_len = 3'd4; end
            default:       ;
        endcase
        w_is_mem = w_is_load | w_is_store;
    end

    always_comb begin
        w_load_ext = mctl_rdata_i;
        case (r_cmd)
            CmdLB:   w_load_ext = {{24{mctl_rdata_i[7]}}, mctl_rdata_i[7:0]};
            CmdLBU:  w_load_ext = {24'h0, mctl_rdata_i[7:0]};
            CmdLH:   w_load_ext = {{16{mctl_rdata_i[15]}}, mctl_rdata_i[15:0]};
            CmdLHU:  w_load_ext = {16'h0, mctl_rdata_i[15:0]};
            default: ;
        endcase
    end

    // Stall is state-based only, so it keeps following done even while rdy_in is low.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        if (r_state == StIdle) begin
            w_stall = w_is_mem;
            if (w_is_mem) begin
                w_state_nxt = StBusy;
            end
        end else begin
            w_stall = !mctl_done_i;
            if (mctl_done_i) begin
                w_state_nxt = StIdle;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= StIdle;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_wdata     <= '0;
            r_cmd       <= '0;
            r_rd        <= '0;
            r_rsd_addr  <= '0;
            r_rsd_data  <= '0;
            r_write_rsd <= 1'b0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            if (r_state == StIdle) begin
                if (w_is_mem) begin
                    r_req       <= 1'b1;
                    r_we        <= w_is_store;
                    r_addr      <= mem_addr_in;
                    r_len       <= w_len;
                    r_wdata     <= store_val_in;
                    r_cmd       <= cmdtype_in;
                    r_rd        <= rsd_addr_in;
                    r_write_rsd <= 1'b0;
                end else begin
                    r_rsd_addr  <= rsd_addr_in;
                    r_rsd_data  <= rsd_data_in;
                    r_write_rsd <= write_rsd_in;
                end
            end else if (mctl_done_i) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_rsd_addr  <= r_rd;
                    r_rsd_data  <= w_load_ext;
                    r_write_rsd <= 1'b1;
                end else begin
                    r_write_rsd <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_FWD_EN
    always_comb begin
        mem_forward_id_o   = 1'b0;
        mem_forward_addr_o = '0;
        mem_forward_data_o = '0;
        if (r_state == StIdle) begin
            if (!w_is_mem && write_rsd_in && (rsd_addr_in != 5'd0)) begin
                mem_forward_id_o   = 1'b1;
                mem_forward_addr_o = rsd_addr_in;
                mem_forward_data_o = rsd_data_in;
            end
        end else if (!r_we && mctl_done_i && (r_rd != 5'd0)) begin
            mem_forward_id_o   = 1'b1;
            mem_forward_addr_o = r_rd;
            mem_forward_data_o = w_load_ext;
        end
    end
`else
    assign mem_forward_id_o   = 1'b0;
    assign mem_forward_addr_o = '0;
    assign mem_forward_data_o = '0;
`endif

    assign mctl_req_o   = r_req;
    assign mctl_we_o    = r_we;
    assign mctl_addr_o  = r_addr;
    assign mctl_len_o   = r_len;
    assign mctl_wdata_o = r_wdata;
    assign rsd_addr_o   = r_rsd_addr;
    assign rsd_data_o   = r_rsd_data;
    assign write_rsd_o  = r_write_rsd;
    assign stall_mem_o  = w_stall;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: write-back results are scoreboarded, handshake checked inline.
module tb_mem_access_unit;

    localparam logic [5:0] CmdNop = 6'd0;
    localparam logic [5:0] CmdUnk = 6'h3F;
    localparam logic [5:0] CmdLB  = 6'd11;
    localparam logic [5:0] CmdLH  = 6'd12;
    localparam logic [5:0] CmdLW  = 6'd13;
    localparam logic [5:0] CmdLBU = 6'd14;
    localparam logic [5:0] CmdLHU = 6'd15;
    localparam logic [5:0] CmdSB  = 6'd16;
    localparam logic [5:0] CmdSH  = 6'd17;
    localparam logic [5:0] CmdSW  = 6'd18;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [4:0]  rsd_addr_in;
    logic [31:0] rsd_data_in;
    logic        write_rsd_in;
    logic [5:0]  cmdtype_in;
    logic [31:0] mem_addr_in;
    logic [31:0] store_val_in;
    logic        mctl_req_o;
    logic        mctl_we_o;
    logic [31:0] mctl_addr_o;
    logic [2:0]  mctl_len_o;
    logic [31:0] mctl_wdata_o;
    logic        mctl_done_i;
    logic [31:0] mctl_rdata_i;
    logic [4:0]  rsd_addr_o;
    logic [31:0] rsd_data_o;
    logic        write_rsd_o;
    logic        stall_mem_o;
    logic        mem_forward_id_o;
    logic [4:0]  mem_forward_addr_o;
    logic [31:0] mem_forward_data_o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        bit          chk_data;
    } wb_t;

    wb_t sb[$];
    int  n_run  = 0;
    int  n_fail = 0;

    mem_access_unit dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .rsd_addr_in        (rsd_addr_in),
        .rsd_data_in        (rsd_data_in),
        .write_rsd_in       (write_rsd_in),
        .cmdtype_in         (cmdtype_in),
        .mem_addr_in        (mem_addr_in),
        .store_val_in       (store_val_in),
        .mctl_req_o         (mctl_req_o),
        .mctl_we_o          (mctl_we_o),
        .mctl_addr_o        (mctl_addr_o),
        .mctl_len_o         (mctl_len_o),
        .mctl_wdata_o       (mctl_wdata_o),
        .mctl_done_i        (mctl_done_i),
        .mctl_rdata_i       (mctl_rdata_i),
        .rsd_addr_o         (rsd_addr_o),
        .rsd_data_o         (rsd_data_o),
        .write_rsd_o        (write_rsd_o),
        .stall_mem_o        (stall_mem_o),
        .mem_forward_id_o   (mem_forward_id_o),
        .mem_forward_addr_o (mem_forward_addr_o),
        .mem_forward_data_o (mem_forward_data_o)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic fwd_on();
`ifdef MEM_FWD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wb_check(input string tag);
        wb_t e;
        chk({tag, "_sb_level"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_wb_we"}, 32'(write_rsd_o), 32'(e.we));
            if (e.chk_data) begin
                chk({tag, "_wb_rd"}, 32'(rsd_addr_o), 32'(e.rd));
                chk({tag, "_wb_data"}, rsd_data_o, e.data);
            end
        end
    endtask

    task automatic idle_inputs();
        cmdtype_in   = CmdNop;
        write_rsd_in = 1'b0;
        rsd_addr_in  = 5'd0;
        rsd_data_in  = 32'd0;
    endtask

    task automatic pass(input string tag, input logic [5:0] cmd, input logic [4:0] rd,
                        input logic [31:0] data, input logic we);
        logic f;
        sb.push_back('{rd: rd, data: data, we: we, chk_data: 1'b1});
        cmdtype_in   = cmd;
        rsd_addr_in  = rd;
        rsd_data_in  = data;
        write_rsd_in = we;
        #1;
        f = fwd_on() && we && (rd != 5'd0);
        chk({tag, "_stall"}, 32'(stall_mem_o), 32'd0);
        chk({tag, "_fwd_id"}, 32'(mem_forward_id_o), 32'(f));
        chk({tag, "_fwd_addr"}, 32'(mem_forward_addr_o), f ? 32'(rd) : 32'd0);
        chk({tag, "_fwd_data"}, mem_forward_data_o, f ? data : 32'd0);
        step();
        wb_check(tag);
    endtask

    task automatic run_mem(input string tag, input logic [5:0] cmd, input logic [31:0] addr,
                           input logic [31:0] sval, input logic [4:0] rd, input int waits,
                           input logic [31:0] rdata, input logic [31:0] exp_data,
                           input logic [2:0] exp_len, input logic is_store);
        logic f;
        if (is_store) sb.push_back('{rd: 5'd0, data: 32'd0, we: 1'b0, chk_data: 1'b0});
        else          sb.push_back('{rd: rd, data: exp_data, we: 1'b1, chk_data: 1'b1});
        cmdtype_in   = cmd;
        mem_addr_in  = addr;
        store_val_in = sval;
        rsd_addr_in  = rd;
        rsd_data_in  = 32'h5A5A_5A5A;
        write_rsd_in = !is_store;
        #1;
        chk({tag, "_stall0"}, 32'(stall_mem_o), 32'd1);
        step();
        chk({tag, "_req"}, 32'(mctl_req_o), 32'd1);
        chk({tag, "_we"}, 32'(mctl_we_o), 32'(is_store));
        chk({tag, "_addr"}, mctl_addr_o, addr);
        chk({tag, "_len"}, 32'(mctl_len_o), 32'(exp_len));
        chk({tag, "_bubble"}, 32'(write_rsd_o), 32'd0);
        if (is_store) chk({tag, "_wdata"}, mctl_wdata_o, sval);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_stall_wait"}, 32'(stall_mem_o), 32'd1);
            step();
            chk({tag, "_req_hold"}, 32'(mctl_req_o), 32'd1);
            chk({tag, "_addr_hold"}, mctl_addr_o, addr);
        end
        mctl_done_i  = 1'b1;
        mctl_rdata_i = rdata;
        #1;
        f = fwd_on() && !is_store && (rd != 5'd0);
        chk({tag, "_stall_done"}, 32'(stall_mem_o), 32'd0);
        chk({tag, "_fwd_id"}, 32'(mem_forward_id_o), 32'(f));
        chk({tag, "_fwd_data"}, mem_forward_data_o, f ? exp_data : 32'd0);
        step();
        mctl_done_i = 1'b0;
        idle_inputs();
        chk({tag, "_req_drop"}, 32'(mctl_req_o), 32'd0);
        wb_check(tag);
    endtask

    initial begin
        rst_in       = 1'b0;
        rdy_in       = 1'b1;
        mctl_done_i  = 1'b0;
        mctl_rdata_i = 32'd0;
        mem_addr_in  = 32'd0;
        store_val_in = 32'd0;
        idle_inputs();
        step();
        step();
        chk("rst_req", 32'(mctl_req_o), 32'd0);
        chk("rst_we", 32'(mctl_we_o), 32'd0);
        chk("rst_write", 32'(write_rsd_o), 32'd0);
        chk("rst_data", rsd_data_o, 32'd0);
        chk("rst_addr", mctl_addr_o, 32'd0);
        chk("rst_stall", 32'(stall_mem_o), 32'd0);
        rst_in = 1'b1;
        step();

        pass("addi", CmdNop, 5'd5, 32'h0000_1234, 1'b1);
        pass("unk", CmdUnk, 5'd3, 32'h8765_4321, 1'b1);
        pass("x0", CmdNop, 5'd0, 32'h0000_0055, 1'b1);
        pass("nowr", CmdNop, 5'd4, 32'h0000_0077, 1'b0);

        run_mem("lb", CmdLB, 32'h100, 32'd0, 5'd6, 2, 32'h0000_00F0, 32'hFFFF_FFF0, 3'd1, 1'b0);
        run_mem("lhu", CmdLHU, 32'h104, 32'd0, 5'd7, 0, 32'h0000_ABCD, 32'h0000_ABCD, 3'd2, 1'b0);
        run_mem("lh", CmdLH, 32'h108, 32'd0, 5'd8, 1, 32'h0000_ABCD, 32'hFFFF_ABCD, 3'd2, 1'b0);
        run_mem("lbu", CmdLBU, 32'h10C, 32'd0, 5'd11, 0, 32'h1234_56F0, 32'h0000_00F0, 3'd1, 1'b0);
        run_mem("lw", CmdLW, 32'h110, 32'd0, 5'd12, 0, 32'h8000_0001, 32'h8000_0001, 3'd4, 1'b0);
        run_mem("sw", CmdSW, 32'h200, 32'hDEAD_BEEF, 5'd0, 0, 32'd0, 32'd0, 3'd4, 1'b1);
        run_mem("sb", CmdSB, 32'h201, 32'h0000_00AA, 5'd0, 1, 32'd0, 32'd0, 3'd1, 1'b1);
        run_mem("sh", CmdSH, 32'h202, 32'h0000_BBCC, 5'd0, 0, 32'd0, 32'd0, 3'd2, 1'b1);
        run_mem("ld_x0", CmdLW, 32'h114, 32'd0, 5'd0, 0, 32'h0000_0099, 32'h0000_0099, 3'd4, 1'b0);

        // Done pulsed while frozen must be lost; a later done completes the load.
        sb.push_back('{rd: 5'd9, data: 32'hCAFE_F00D, we: 1'b1, chk_data: 1'b1});
        cmdtype_in   = CmdLW;
        mem_addr_in  = 32'h300;
        rsd_addr_in  = 5'd9;
        write_rsd_in = 1'b1;
        step();
        chk("rdy_req", 32'(mctl_req_o), 32'd1);
        rdy_in       = 1'b0;
        mctl_done_i  = 1'b1;
        mctl_rdata_i = 32'h1111_1111;
        step();
        mctl_done_i = 1'b0;
        chk("rdy_frozen_req", 32'(mctl_req_o), 32'd1);
        chk("rdy_frozen_wr", 32'(write_rsd_o), 32'd0);
        chk("rdy_frozen_addr", mctl_addr_o, 32'h300);
        rdy_in = 1'b1;
        step();
        chk("rdy_still_busy", 32'(mctl_req_o), 32'd1);
        chk("rdy_stall", 32'(stall_mem_o), 32'd1);
        mctl_done_i  = 1'b1;
        mctl_rdata_i = 32'hCAFE_F00D;
        step();
        mctl_done_i = 1'b0;
        idle_inputs();
        chk("rdy_req_drop", 32'(mctl_req_o), 32'd0);
        wb_check("rdy");

        // Reset mid-access; the trailing done must not produce a write-back.
        cmdtype_in   = CmdLW;
        mem_addr_in  = 32'h400;
        rsd_addr_in  = 5'd10;
        write_rsd_in = 1'b1;
        step();
        chk("mid_req", 32'(mctl_req_o), 32'd1);
        rst_in = 1'b0;
        step();
        idle_inputs();
        rst_in       = 1'b1;
        mctl_done_i  = 1'b1;
        mctl_rdata_i = 32'h0000_FFFF;
        #1;
        chk("mid_stall_idle", 32'(stall_mem_o), 32'd0);
        step();
        mctl_done_i = 1'b0;
        chk("mid_req", 32'(mctl_req_o), 32'd0);
        chk("mid_write", 32'(write_rsd_o), 32'd0);
        chk("mid_data", rsd_data_o, 32'd0);
        chk("mid_rd", 32'(rsd_addr_o), 32'd0);
        chk("mid_addr", mctl_addr_o, 32'd0);
        step();
        chk("mid_req_after", 32'(mctl_req_o), 32'd0);
        chk("mid_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Memory-access (MEM) pipeline stage of the RISC-V core, with the MEM/WB pipeline latch inside it.
- Consumes the execute stage's outputs: destination register, ALU result, command type, effective address and store value.
- Loads and stores run through a request/done handshake with the memory controller. Other commands pass straight through to write-back.
- The block stalls the upstream pipeline while an access is outstanding and forwards its result to decode.

## Interface
- CMD_W, 6, width of the command-type code (`Cmd_Typebus`). Codes come from the shared `define.v` (`CmdLB`…`CmdSW`).
- clk_in  in  1  clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low freezes every register
- rsd_addr_in  in  5  destination register from EX/MEM latch
- rsd_data_in  in  32  ALU result
- write_rsd_in  in  1  register write enable
- cmdtype_in  in  CMD_W  command type
- mem_addr_in  in  32  effective address
- store_val_in  in  32  store data
- mctl_req_o  out  1  access request to memory controller
- mctl_we_o  out  1  1 = store
- mctl_addr_o  out  32  access address
- mctl_len_o  out  3  byte count: 1, 2 or 4
- mctl_wdata_o  out  32  store data, low bytes valid
- mctl_done_i  in  1  one-cycle completion pulse
- mctl_rdata_i  in  32  load data, valid with done, zero-extended
- rsd_addr_o  out  5  to register file (registered)
- rsd_data_o  out  32  write-back data (registered)
- write_rsd_o  out  1  write-back enable (registered)
- stall_mem_o  out  1  hold IF/ID/EX and EX/MEM latches
- mem_forward_id_o  out  1  forward valid to decode
- mem_forward_addr_o  out  5  forwarded register
- mem_forward_data_o  out  32  forwarded value

## Operation
- **States:** IDLE, BUSY.
- **Reset** (rst_in low at edge): state = IDLE. mctl_req_o, mctl_we_o, write_rsd_o = 0. All data/address outputs = 0. An outstanding access is abandoned and a later done is ignored.
- **IDLE, non-memory command:** at the edge, latch rsd_addr_in, rsd_data_in and write_rsd_in to the outputs. No stall.
- **IDLE, load/store command:**
  - stall_mem_o = 1 combinationally.
  - At the edge: go to BUSY; mctl_req_o = 1; mctl_addr_o = mem_addr_in; mctl_we_o = store; mctl_wdata_o = store_val_in.
  - mctl_len_o = 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 for LW/SW.
  - Command type and destination are captured internally.
  - write_rsd_o = 0 (bubble) while the access is outstanding.
- **BUSY:**
  - Request fields are held stable.
  - stall_mem_o = !mctl_done_i.
  - On the done edge: mctl_req_o = 0, go to IDLE.
  - Load: write_rsd_o = 1, rsd_data_o = extended data. Store: write_rsd_o = 0.
- **Load extension:**
  - LB: sign-extend rdata[7:0].
  - LBU: zero-extend rdata[7:0].
  - LH: sign-extend rdata[15:0].
  - LHU: zero-extend rdata[15:0].
  - LW: rdata unchanged.
- **Forwarding (combinational):**
  - IDLE, non-memory command, write_rsd_in and rsd_addr_in != 0: forward rsd_addr_in / rsd_data_in.
  - BUSY, load, mctl_done_i and captured rd != 0: forward the extended load data.
  - Otherwise mem_forward_id_o = 0, with address and data = 0.
- **mctl_done_i while IDLE:** ignored.
- **Unknown command codes:** treated as non-memory pass-through.

## Timing
- Non-memory command: 1 cycle, input to registered output.
- Load/store: minimum 2 cycles. Cycle 0 is IDLE with the command presented. Request is high from cycle 1. Done may arrive in cycle 1 at the earliest.
- The controller may hold done low for any number of cycles; the request stays asserted and stable the whole time.
- The upstream latch advances on the same edge that samples done, so the next command is presented in the following IDLE cycle.
- rdy_in low: state, outputs and request are frozen. Done is not sampled. stall_mem_o still follows the state-based equations above.
- rst_in low overrides rdy_in.

## Configuration
- `MEM_FWD_EN` defined: the forwarding logic is compiled in, as specified above.
- `MEM_FWD_EN` not defined: mem_forward_id_o, mem_forward_addr_o and mem_forward_data_o are tied to 0. Decode must rely on stalls instead.
- Stage behaviour is otherwise identical.

## Test plan
- **Reset:** rst_in=0 mid-BUSY, then done=1 on the next cycle → state IDLE, mctl_req_o=0, write_rsd_o=0, no write-back.
- **ADDI pass-through:** rd=5, data=0x1234, write=1 → next edge rsd_addr_o=5, rsd_data_o=0x1234, write_rsd_o=1; forward valid in the same cycle; stall_mem_o=0.
- **LB sign extension:** addr 0x100, done after 3 cycles with rdata=0x000000F0 → mctl_len_o=1 and req held 3 cycles; stall_mem_o=1 until done; rsd_data_o=0xFFFFFFF0; forward data 0xFFFFFFF0 in the done cycle.
- **LHU:** rdata=0x0000ABCD → rsd_data_o=0x0000ABCD. **LH:** same rdata → rsd_data_o=0xFFFFABCD.
- **SW:** addr 0x200, value 0xDEADBEEF, done in the first request cycle → mctl_we_o=1, mctl_len_o=4, wdata=0xDEADBEEF; total 2 cycles; write_rsd_o=0.
- **rdy_in low during BUSY** with done pulsed → pulse ignored, request still high; a second done with rdy_in=1 completes normally. Also: write to x0 → mem_forward_id_o=0.
